icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's instruction port. Hits return the instruction combinationally in the request cycle. A miss issues one word fetch through the `mc_*` handshake, which the memory controller serves byte-serially. The cache then installs the word and returns it to fetch.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS; the index is `addr[INDEX_BITS+1:2]` and the tag is `addr[31:INDEX_BITS+2]`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state and registered outputs hold.
- `flush` in 1: one-cycle pulse; invalidates all lines.
- `if_req` in 1: fetch requests the word at `if_addr`; held high until `if_ready`.
- `if_addr` in 32: fetch address; `[1:0]` is ignored.
- `if_ready` out 1: combinational; `if_instr` is valid this cycle for `if_addr`.
- `if_instr` out 32: instruction word.
- `mc_req` out 1: registered; request to the memory controller (its `instr_out_enable`).
- `mc_addr` out 32: registered; word address `{if_addr[31:2],2'b00}` of the pending miss.
- `mc_valid` in 1: one-cycle pulse; `mc_instr` holds the fetched word.
- `mc_instr` in 32: fetched word, little-endian assembled by the controller.

## Operation
- Storage: `data[2^INDEX_BITS]` holds 32-bit words, `tag[2^INDEX_BITS]` holds (30-INDEX_BITS)-bit tags, and `valid[2^INDEX_BITS]` holds 1-bit flags.
- `hit` = `valid[idx] && tag[idx]==if_addr tag`.
- FSM states: IDLE and MISS.
- In IDLE with `if_req && hit`, `if_ready=1` and `if_instr=data[idx]`, in the same cycle.
- In IDLE with `if_req && !hit`, the next edge (rdy high) goes to MISS and sets `mc_req<=1` and `mc_addr<=aligned if_addr`. It also latches `miss_addr`.
- In MISS, `mc_req` stays high until `mc_valid` is seen. On the `mc_valid` edge:
  - write `data/tag` at the `miss_addr` index and set its valid bit;
  - `mc_req<=0`;
  - state goes to IDLE.
- In MISS with `mc_valid` high in the current cycle:
  - if `if_addr[31:2]==miss_addr[31:2]`, `if_ready=1` and `if_instr=mc_instr` (bypass);
  - otherwise `if_ready=0`.
- In MISS with `mc_valid` low, `if_ready=0`.
- Fetch redirect mid-miss (`if_addr` changes or `if_req` drops): the outstanding transaction completes and is installed. No abort is ever signalled to the controller.
- `flush` in IDLE clears all valid bits at the edge. In the flush cycle, `if_ready` is forced to 0.
- `flush` in MISS:
  - clears all valid bits and sets `discard`;
  - the returning word is not installed and not bypassed;
  - `discard` clears on return to IDLE.
- `flush` coincident with `mc_valid`: the flush wins; no install and no bypass.
- `mc_valid` while in IDLE is ignored.
- `rst` has priority over everything; reset mid-miss drops the transaction, since the controller is reset by the same `rst`.
- With `rdy` low, `if_ready` is forced to 0.

## Timing
- Reset values: state IDLE, all valid bits 0, `mc_req=0`, `mc_addr=0`, `discard=0`, `if_ready=0`, `if_instr=0` when not ready.
- Hit latency: 0 cycles (same cycle as `if_req`).
- Miss latency:
  - cycle 0: miss detected;
  - cycle 1: `mc_req` high;
  - the controller returns `mc_valid` 6 cycles after `mc_req` rises;
  - `if_ready` comes in cycle 7, via bypass.
- `mc_req` falls the edge after `mc_valid`. The earliest next `mc_req` rise is one cycle later, from a new IDLE miss.
  - This guarantees `mc_req` is low when the controller re-enters IDLE, so there is no duplicate fetch.
- `mc_addr` is stable for the whole time `mc_req` is high.
- Only one outstanding miss; no prefetch.

## Test plan
- Cold miss:
  - stimulus: after reset, `if_req`, `if_addr=0x00000000`, memory word `0x00500093`;
  - response: `mc_req` rises in cycle 1 with `mc_addr=0`; `if_ready` is high in cycle 7 with `if_instr=0x00500093`; `mc_req` is low in cycle 8.
- Hit after fill:
  - stimulus: re-request `0x00000000`;
  - response: `if_ready=1` in the same cycle and `mc_req` stays 0.
- Conflict eviction (`INDEX_BITS=6`):
  - stimulus: fill `0x00000004`, then request `0x00000104` (same index);
  - response: the second request misses; a later `0x00000004` misses again.
- Redirect mid-miss:
  - stimulus: miss on `0x10`, then switch `if_addr` to `0x20` at cycle 3;
  - response: `0x10` is installed with no `if_ready` at `mc_valid`; `0x20` then starts its own miss, and a later `0x10` request hits.
- Flush during miss:
  - stimulus: `flush` pulse in cycle 4 of a miss on `0x40`;
  - response: no `if_ready` at `mc_valid`; `0x40` and every prior line miss afterwards.
- Freeze and reset:
  - stimulus: hold `rdy=0` for 5 cycles mid-miss, then `rdy=1`;
  - response: the completion is delayed exactly 5 cycles;
  - stimulus: assert `rst` mid-miss;
  - response: `mc_req=0` and all lines invalid on the next cycle.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller's byte-serial instruction port.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_instr,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_instr
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state, state_next;

  logic [31:0]         data [LINES];
  logic [TAG_BITS-1:0] tag  [LINES];
  logic [LINES-1:0]    valid;
  logic                discard;

  logic [31:0]           word_addr;
  logic [31:0]           miss_addr;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;

  logic start_miss;
  logic finish_miss;
  logic install;

  // mc_addr already holds the aligned address of the outstanding miss for
  // the whole transaction, so it doubles as the latched miss address.
  assign word_addr = if_addr & 32'hFFFF_FFFC;
  assign miss_addr = mc_addr;
  assign req_idx   = word_addr[INDEX_BITS+1:2];
  assign req_tag   = word_addr[31:INDEX_BITS+2];
  assign miss_idx  = miss_addr[INDEX_BITS+1:2];
  assign miss_tag  = miss_addr[31:INDEX_BITS+2];
  assign hit       = valid[req_idx] && (tag[req_idx] == req_tag);

  always_comb begin
    state_next  = state;
    if_ready    = 1'b0;
    if_instr    = 32'h0;
    start_miss  = 1'b0;
    finish_miss = 1'b0;
    install     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req) begin
          if (hit) begin
            if_ready = 1'b1;
            if_instr = data[req_idx];
          end else begin
            start_miss = 1'b1;
            state_next = MISS;
          end
        end
      end
      MISS: begin
        if (mc_valid) begin
          finish_miss = 1'b1;
          state_next  = IDLE;
          // A flush now or earlier in this miss makes the returning word stale.
          if (!discard && !flush) begin
            install = 1'b1;
            if (word_addr == miss_addr) begin
              if_ready = 1'b1;
              if_instr = mc_instr;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rdy || flush) begin
      if_ready = 1'b0;
      if_instr = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      mc_req  <= 1'b0;
      mc_addr <= 32'h0;
      discard <= 1'b0;
    end else if (rdy) begin
      state <= state_next;
      if (start_miss) begin
        mc_req  <= 1'b1;
        mc_addr <= word_addr;
      end
      if (finish_miss) begin
        mc_req  <= 1'b0;
        discard <= 1'b0;
      end else if (state == MISS && flush) begin
        discard <= 1'b1;
      end
      if (flush) begin
        valid <= '0;
      end else if (install) begin
        valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Line payloads need no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && install) begin
      data[miss_idx] <= mc_instr;
      tag[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches
// checked against a per-index residency model and a frozen-aware memory model.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid = 1'b0;
  logic [31:0] mc_instr = 32'hDEAD_BEEF;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] res_addr [64];
  logic        res_v    [64];
  int          mc_cnt = 0;

  icache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_instr (if_instr),
    .mc_req   (mc_req),
    .mc_addr  (mc_addr),
    .mc_valid (mc_valid),
    .mc_instr (mc_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0) return 32'h0050_0093;
    return w * 32'h9E37_79B1 + 32'h13;
  endfunction

  // Controller: answers 6 enabled cycles after mc_req rises, frozen by rdy.
  always @(posedge clk) begin
    if (rst) begin
      mc_cnt   <= 0;
      mc_valid <= 1'b0;
      mc_instr <= 32'hDEAD_BEEF;
    end else if (rdy) begin
      if (mc_valid) begin
        mc_valid <= 1'b0;
        mc_cnt   <= 0;
        mc_instr <= 32'hDEAD_BEEF;
      end else if (mc_req) begin
        if (mc_cnt == 5) begin
          mc_valid <= 1'b1;
          mc_instr <= mem_word(mc_addr);
        end
        mc_cnt <= mc_cnt + 1;
      end
    end
  end

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return res_v[idx_of(a)] && (res_addr[idx_of(a)] == (a & 32'hFFFF_FFFC));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    res_v[idx_of(a)]    = 1'b1;
    res_addr[idx_of(a)] = a & 32'hFFFF_FFFC;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) res_v[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch and reports what it saw; callers do the comparisons.
  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] instr,
                       output int req_cycle, output logic [31:0] req_addr,
                       output logic req_after);
    lat = -1;
    instr = 32'h0;
    req_cycle = -1;
    req_addr = 32'h0;
    if_addr = a;
    if_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mc_req && req_cycle < 0) begin
        req_cycle = c;
        req_addr = mc_addr;
      end
      if (if_ready) begin
        lat = c;
        instr = if_instr;
        break;
      end
      step();
    end
    step();
    if_req = 1'b0;
    req_after = mc_req;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (if_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_ready got %b want 0", if_ready); end
    vectors++;
    if (if_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_instr got %h want 0", if_instr); end
    vectors++;
    if (mc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mc_req got %b want 0", mc_req); end
    vectors++;
    if (mc_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mc_addr got %h want 0", mc_addr); end
    step();
  endtask

  task automatic test_cold_miss();
    int lat, rc;
    logic [31:0] instr, ra;
    logic after;
    fetch(32'h0, lat, instr, rc, ra, after);
    model_fill(32'h0);
    vectors++;
    if (rc !== 1) begin miscompares++; $display("[TB] FAIL cold_mc_req_cycle got %0d want 1", rc); end
    vectors++;
    if (ra !== 32'h0) begin miscompares++; $display("[TB] FAIL cold_mc_addr got %h want 0", ra); end
    vectors++;
    if (lat !== 7) begin miscompares++; $display("[TB] FAIL cold_latency got %0d want 7", lat); end
    vectors++;
    if (instr !== 32'h0050_0093) begin miscompares++; $display("[TB] FAIL cold_instr got %h want 00500093", instr); end
    vectors++;
    if (after !== 1'b0) begin miscompares++; $display("[TB] FAIL cold_mc_req_cycle8 got %b want 0", after); end
  endtask

  task automatic test_hit();
    int lat, rc;
    logic [31:0] instr, ra;
    logic after;
    fetch(32'h0, lat, instr, rc, ra, after);
    vectors++;
    if (lat !== 0) begin miscompares++; $display("[TB] FAIL hit_latency got %0d want 0", lat); end
    vectors++;
    if (instr !== 32'h0050_0093) begin miscompares++; $display("[TB] FAIL hit_instr got %h want 00500093", instr); end
    vectors++;
    if (rc !== -1) begin miscompares++; $display("[TB] FAIL hit_mc_req got cycle %0d want never", rc); end
  endtask

  task automatic test_conflict();
    logic [31:0] seq [3];
    int lat, rc;
    logic [31:0] instr, ra;
    logic after;
    seq[0] = 32'h4;
    seq[1] = 32'h104;
    seq[2] = 32'h4;
    for (int i = 0; i < 3; i++) begin
      fetch(seq[i], lat, instr, rc, ra, after);
      model_fill(seq[i]);
      vectors++;
      if (lat !== 7) begin miscompares++; $display("[TB] FAIL conflict_latency addr %h got %0d want 7", seq[i], lat); end
      vectors++;
      if (instr !== mem_word(seq[i])) begin miscompares++; $display("[TB] FAIL conflict_instr addr %h got %h want %h", seq[i], instr, mem_word(seq[i])); end
    end
  endtask

  task automatic test_redirect();
    int lat, rc;
    bit early_ready;
    logic [31:0] first_addr, instr, ra;
    logic after;
    lat = -1;
    early_ready = 1'b0;
    first_addr = 32'h0;
    instr = 32'h0;
    if_addr = 32'h10;
    if_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) if_addr = 32'h20;
      @(negedge clk);
      if (c == 1) first_addr = mc_addr;
      if (c <= 7 && if_ready) early_ready = 1'b1;
      if (if_ready) begin
        lat = c;
        instr = if_instr;
        break;
      end
      step();
    end
    step();
    if_req = 1'b0;
    model_fill(32'h10);
    model_fill(32'h20);
    vectors++;
    if (first_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL redirect_first_mc_addr got %h want 00000010", first_addr); end
    vectors++;
    if (early_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL redirect_bypass got ready=%b want 0", early_ready); end
    vectors++;
    if (lat !== 15) begin miscompares++; $display("[TB] FAIL redirect_second_latency got %0d want 15", lat); end
    vectors++;
    if (instr !== mem_word(32'h20)) begin miscompares++; $display("[TB] FAIL redirect_second_instr got %h want %h", instr, mem_word(32'h20)); end
    fetch(32'h10, lat, instr, rc, ra, after);
    vectors++;
    if (lat !== 0) begin miscompares++; $display("[TB] FAIL redirect_installed_hit got %0d want 0", lat); end
    vectors++;
    if (instr !== mem_word(32'h10)) begin miscompares++; $display("[TB] FAIL redirect_installed_instr got %h want %h", instr, mem_word(32'h10)); end
  endtask

  task automatic test_flush_miss();
    logic [31:0] seq [5];
    bit seen_ready;
    int lat, rc;
    logic [31:0] instr, ra;
    logic after;
    seen_ready = 1'b0;
    if_addr = 32'h40;
    if_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      flush = (c == 4);
      @(negedge clk);
      if (if_ready) seen_ready = 1'b1;
      step();
    end
    flush = 1'b0;
    if_req = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (seen_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_miss_bypass got ready=%b want 0", seen_ready); end
    vectors++;
    if (mc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_miss_mc_req_end got %b want 0", mc_req); end
    step();
    seq[0] = 32'h40;
    seq[1] = 32'h0;
    seq[2] = 32'h104;
    seq[3] = 32'h10;
    seq[4] = 32'h20;
    for (int i = 0; i < 5; i++) begin
      fetch(seq[i], lat, instr, rc, ra, after);
      model_fill(seq[i]);
      vectors++;
      if (lat !== 7) begin miscompares++; $display("[TB] FAIL flush_refill_latency addr %h got %0d want 7", seq[i], lat); end
    end
  endtask

  task automatic test_freeze();
    int lat;
    logic [31:0] instr, stall_addr;
    logic stall_req;
    lat = -1;
    instr = 32'h0;
    stall_addr = 32'h0;
    stall_req = 1'b0;
    if_addr = 32'h83;
    if_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rdy = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (c == 5) begin
        stall_req = mc_req;
        stall_addr = mc_addr;
      end
      if (if_ready) begin
        lat = c;
        instr = if_instr;
        break;
      end
      step();
    end
    rdy = 1'b1;
    step();
    if_req = 1'b0;
    model_fill(32'h80);
    vectors++;
    if (lat !== 12) begin miscompares++; $display("[TB] FAIL freeze_latency got %0d want 12", lat); end
    vectors++;
    if (instr !== mem_word(32'h80)) begin miscompares++; $display("[TB] FAIL freeze_instr got %h want %h", instr, mem_word(32'h80)); end
    vectors++;
    if (stall_req !== 1'b1 || stall_addr !== 32'h80) begin miscompares++; $display("[TB] FAIL freeze_mc_hold got req=%b addr=%h want 1 00000080", stall_req, stall_addr); end
    rdy = 1'b0;
    if_addr = 32'h80;
    if_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (if_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL freeze_hit_masked got %b want 0", if_ready); end
    step();
    rdy = 1'b1;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_miss();
    int lat, rc;
    logic [31:0] instr, ra;
    logic after;
    if_addr = 32'hC0;
    if_req = 1'b1;
    for (int c = 0; c < 3; c++) step();
    rst = 1'b1;
    if_req = 1'b0;
    step();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (mc_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid_miss_mc_req got %b want 0", mc_req); end
    step();
    fetch(32'h80, lat, instr, rc, ra, after);
    model_fill(32'h80);
    vectors++;
    if (lat !== 7) begin miscompares++; $display("[TB] FAIL reset_mid_miss_invalid got latency %0d want 7", lat); end
  endtask

  task automatic test_random();
    logic [31:0] a, last;
    int lat, rc, exp_lat;
    logic [31:0] instr, ra;
    logic after;
    last = 32'h80;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        if_addr = last;
        if_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (if_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL random_flush_ready addr %h got %b want 0", last, if_ready); end
        step();
        flush = 1'b0;
        if_req = 1'b0;
        model_clear();
        step();
      end
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      exp_lat = model_hit(a) ? 0 : 7;
      fetch(a, lat, instr, rc, ra, after);
      model_fill(a);
      last = a;
      vectors++;
      if (lat !== exp_lat) begin miscompares++; $display("[TB] FAIL random_latency addr %h got %0d want %0d", a, lat, exp_lat); end
      vectors++;
      if (instr !== mem_word(a)) begin miscompares++; $display("[TB] FAIL random_instr addr %h got %h want %h", a, instr, mem_word(a)); end
      vectors++;
      if (after !== 1'b0) begin miscompares++; $display("[TB] FAIL random_mc_req_after addr %h got %b want 0", a, after); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_redirect();
    test_flush_miss();
    test_freeze();
    test_reset_mid_miss();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
